sync_filt_c: RTL

- Parametrised multi-channel synchroniser for asynchronous level inputs such as pins, trigger lines and cross-domain status bits.
- Each channel has a configurable-depth flop chain, an optional stability (debounce) filter, registered-source rise/fall pulses, and a sticky rejected-glitch flag.
- Sits at every async boundary feeding the capture/trigger logic, replacing fixed two-flop single-bit synchronisers.

---
 rtl/sync_filt_c.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sync_filt_c.sv
// sync_filt_c: multi-channel synchroniser for asynchronous level inputs.
//
// Each channel runs its input through a STAGES-deep flop chain, then an
// optional stability filter that only lets the output follow the synced
// level once it has differed for FILT_CYCLES consecutive edges. Rise/fall
// pulses come from comparing the output against a one-cycle history flop,
// and a sticky flag records pulses the filter threw away.
//
// Ports:
//   clk         sole clock
//   reset_      asynchronous active-low reset (release is clk-synchronous
//               upstream)
//   sync_in     [WIDTH] asynchronous level inputs
//   glitch_clr  [WIDTH] synchronous per-channel clear of glitch
//   sync_out    [WIDTH] synchronised, filtered level
//   rise        [WIDTH] one-cycle pulse on sync_out 0->1
//   fall        [WIDTH] one-cycle pulse on sync_out 1->0
//   any_change  OR of all rise/fall bits
//   glitch      [WIDTH] sticky: a too-short pulse was rejected
module sync_filt_c #(
    parameter int               WIDTH       = 1,
    parameter int               STAGES      = 2,
    parameter int               FILT_CYCLES = 0,
    parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic [WIDTH-1:0] sync_in,
    input  logic [WIDTH-1:0] glitch_clr,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_change,
    output logic [WIDTH-1:0] glitch
);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("sync_filt_c: STAGES must be >= 2");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("sync_filt_c: WIDTH must be >= 1");
        end
        if (FILT_CYCLES < 0) begin : g_bad_filt
            $error("sync_filt_c: FILT_CYCLES must be >= 0");
        end
    endgenerate

    // Last flop of each synchroniser chain.
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] hist_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            // Bit 0 is the metastability-catching flop; the top bit is raw.
            logic [STAGES-1:0] chain_reg;

            always_ff @(posedge clk or negedge reset_) begin
                if (!reset_) begin
                    chain_reg <= {STAGES{RESET_VAL[gi]}};
                end else begin
                    chain_reg <= {chain_reg[STAGES-2:0], sync_in[gi]};
                end
            end

            assign raw[gi] = chain_reg[STAGES-1];

            if (FILT_CYCLES == 0) begin : g_bypass
                // Output taps the chain directly; nothing can be rejected.
                logic unused_clr;
                assign unused_clr  = glitch_clr[gi];
                assign sync_out[gi] = raw[gi];
                assign glitch[gi]   = 1'b0;
            end else begin : g_filt
                localparam int CNT_W = (FILT_CYCLES < 2) ? 1 : $clog2(FILT_CYCLES + 1);
                localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

                logic             filt_reg;
                logic [CNT_W-1:0] cnt_reg;
                logic             glitch_reg;
                logic             reject;

                // raw fell back to the filtered level part-way through a count.
                assign reject = (raw[gi] == filt_reg) && (cnt_reg != '0);

                always_ff @(posedge clk or negedge reset_) begin
                    if (!reset_) begin
                        filt_reg   <= RESET_VAL[gi];
                        cnt_reg    <= '0;
                        glitch_reg <= 1'b0;
                    end else begin
                        if (raw[gi] == filt_reg) begin
                            cnt_reg <= '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            filt_reg <= raw[gi];
                            cnt_reg  <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                        // A rejection on the same edge as a clear keeps the flag.
                        glitch_reg <= reject | (glitch_reg & ~glitch_clr[gi]);
                    end
                end

                assign sync_out[gi] = filt_reg;
                assign glitch[gi]   = glitch_reg;
            end
        end
    endgenerate

    // History resets to the same value as the output, so neither reset
    // assertion nor release can produce an edge pulse.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            hist_reg <= RESET_VAL;
        end else begin
            hist_reg <= sync_out;
        end
    end

    assign rise       = sync_out & ~hist_reg;
    assign fall       = ~sync_out & hist_reg;
    assign any_change = |(rise | fall);

endmodule
